// File: rtl/tt_vfp_encoder_seq_if.sv
// Handshake bundle between the operand requester, the encoder sequencer and the
// downstream FP pipeline. The sequencer binds to the slave modport.
interface tt_vfp_encoder_seq_if #(
  parameter int NUM_LANES = 4,
  parameter int TAG_W     = 6
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [64*NUM_LANES-1:0] i_req_data;
  logic [1:0]              i_req_sew;
  logic                    i_req_widen;
  logic [TAG_W-1:0]        i_req_tag;
  logic                    i_flush;
  logic [64*NUM_LANES-1:0] o_enc_data;
  logic                    o_enc_sel;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic                    o_rsp_beat;
  logic                    o_rsp_last;
  logic [TAG_W-1:0]        o_rsp_tag;
  logic                    o_rsp_illegal;

  modport slave (
    input  i_req_valid, i_req_data, i_req_sew, i_req_widen, i_req_tag, i_flush, i_rsp_ready,
    output o_req_ready, o_enc_data, o_enc_sel, o_rsp_valid, o_rsp_beat, o_rsp_last,
           o_rsp_tag, o_rsp_illegal
  );

  modport master (
    output i_req_valid, i_req_data, i_req_sew, i_req_widen, i_req_tag, i_flush, i_rsp_ready,
    input  o_req_ready, o_enc_data, o_enc_sel, o_rsp_valid, o_rsp_beat, o_rsp_last,
           o_rsp_tag, o_rsp_illegal
  );
endinterface

// File: rtl/tt_vfp_encoder_seq.sv
// Sequencer feeding vector operands into NUM_LANES FP encoder lanes: one beat for
// same-width requests, two beats (low then high 32-bit halves) for widening requests.
module tt_vfp_encoder_seq #(
  parameter int NUM_LANES = 4,
  parameter int TAG_W     = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  tt_vfp_encoder_seq_if.slave  bus
);
  localparam int DW = 64 * NUM_LANES;
  localparam int HW = 32 * NUM_LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t           state_q;
  logic [DW-1:0]    enc_data_q;
  logic [HW-1:0]    hi_q;
  logic             enc_sel_q;
  logic             valid_q;
  logic             beat_q;
  logic             last_q;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;

  logic [DW-1:0]    lo_ext;
  logic [DW-1:0]    hi_ext;
  logic [HW-1:0]    hi_in;
  logic             widen_eff;
  logic             widen_bad;
  logic             rsp_fire;
  logic             req_ready;
  logic             accept;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lo_ext = '0;
    hi_ext = '0;
    hi_in  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lo_ext[64*k +: 32] = bus.i_req_data[64*k +: 32];
      hi_in[32*k +: 32]  = bus.i_req_data[64*k+32 +: 32];
      hi_ext[64*k +: 32] = hi_q[32*k +: 32];
    end
  end

  assign widen_eff = bus.i_req_widen & ((bus.i_req_sew == 2'b01) | (bus.i_req_sew == 2'b10));
  assign widen_bad = bus.i_req_widen & ((bus.i_req_sew == 2'b11) | (bus.i_req_sew == 2'b00));
  assign rsp_fire  = valid_q & bus.i_rsp_ready;

  // Combinational from i_rsp_ready so a new request can follow the last beat directly.
  assign req_ready = ~bus.i_flush & ((state_q == IDLE) | (rsp_fire & last_q));
  assign accept    = bus.i_req_valid & req_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      enc_data_q <= '0;
      hi_q       <= '0;
      enc_sel_q  <= 1'b0;
      valid_q    <= 1'b0;
      beat_q     <= 1'b0;
      last_q     <= 1'b0;
      tag_q      <= '0;
      illegal_q  <= 1'b0;
    end else if (bus.i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      state_q    <= BEAT0;
      valid_q    <= 1'b1;
      beat_q     <= 1'b0;
      tag_q      <= bus.i_req_tag;
      illegal_q  <= widen_bad;
      hi_q       <= hi_in;
      enc_sel_q  <= widen_eff;
      last_q     <= ~widen_eff;
      enc_data_q <= widen_eff ? lo_ext : bus.i_req_data;
    end else if (rsp_fire) begin
      if (state_q == BEAT0 && !last_q) begin
        state_q    <= BEAT1;
        beat_q     <= 1'b1;
        last_q     <= 1'b1;
        enc_data_q <= hi_ext;
      end else begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_req_ready   = req_ready;
  assign bus.o_enc_data    = enc_data_q;
  assign bus.o_enc_sel     = enc_sel_q;
  assign bus.o_rsp_valid   = valid_q;
  assign bus.o_rsp_beat    = beat_q;
  assign bus.o_rsp_last    = last_q;
  assign bus.o_rsp_tag     = tag_q;
  assign bus.o_rsp_illegal = illegal_q;
endmodule

// File: tb/tb_tt_vfp_encoder_seq.sv
// Directed bench for tt_vfp_encoder_seq: reset, single beat, widen, back-to-back
// with stall, illegal widen and flush.
module tb_tt_vfp_encoder_seq;
  localparam int NL = 4;
  localparam int TW = 6;
  localparam int DW = 64 * NL;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  tt_vfp_encoder_seq_if #(.NUM_LANES(NL), .TAG_W(TW)) bus ();

  tt_vfp_encoder_seq #(.NUM_LANES(NL), .TAG_W(TW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, sel, beat, last, illegal, tag}
  logic [10:0] ctl;
  assign ctl = {bus.o_rsp_valid, bus.o_enc_sel, bus.o_rsp_beat, bus.o_rsp_last,
                bus.o_rsp_illegal, bus.o_rsp_tag};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [DW-1:0] d, input logic [1:0] sew,
                           input logic w, input logic [TW-1:0] tag);
    bus.i_req_valid = v;
    bus.i_req_data  = d;
    bus.i_req_sew   = sew;
    bus.i_req_widen = w;
    bus.i_req_tag   = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(1'b0, '0, 2'b00, 1'b0, '0);
    bus.i_flush     = 1'b0;
    bus.i_rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (ctl !== 11'd0) begin
      $display("FAIL reset_ctl: got %b want %b", ctl, 11'd0);
      fails++;
    end
    tests++;
    if (bus.o_req_ready !== 1'b1) begin
      $display("FAIL reset_req_ready: got %b want 1", bus.o_req_ready);
      fails++;
    end
    tests++;
    if (bus.o_enc_data !== '0) begin
      $display("FAIL reset_enc_data: got %h want 0", bus.o_enc_data);
      fails++;
    end
  endtask

  task automatic test_nonwiden();
    logic [DW-1:0] d;
    d = {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D, 64'h3F80_0000_4000_0000,
         64'h4049_0FDB_3F80_0000};
    drive_req(1'b1, d, 2'b10, 1'b0, 6'd5);
    step();
    drive_req(1'b0, '0, 2'b00, 1'b0, '0);
    tests++;
    if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd5}) begin
      $display("FAIL nonwiden_ctl: got %b want %b", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd5});
      fails++;
    end
    tests++;
    if (bus.o_enc_data !== d) begin
      $display("FAIL nonwiden_data: got %h want %h", bus.o_enc_data, d);
      fails++;
    end
    step();
    tests++;
    if (bus.o_rsp_valid !== 1'b0) begin
      $display("FAIL nonwiden_done: got valid %b want 0", bus.o_rsp_valid);
      fails++;
    end
  endtask

  task automatic test_widen();
    logic [DW-1:0] d;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    d  = {64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'h1111_2222_3333_4444,
          64'h4400_4000_3C00_3800};
    e0 = {64'h0000_0000_7777_8888, 64'h0000_0000_BBBB_CCCC, 64'h0000_0000_3333_4444,
          64'h0000_0000_3C00_3800};
    e1 = {64'h0000_0000_5555_6666, 64'h0000_0000_9999_AAAA, 64'h0000_0000_1111_2222,
          64'h0000_0000_4400_4000};
    drive_req(1'b1, d, 2'b01, 1'b1, 6'd9);
    step();
    drive_req(1'b0, '0, 2'b00, 1'b0, '0);
    tests++;
    if (ctl !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9}) begin
      $display("FAIL widen_b0_ctl: got %b want %b", ctl, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9});
      fails++;
    end
    tests++;
    if (bus.o_enc_data !== e0) begin
      $display("FAIL widen_b0_data: got %h want %h", bus.o_enc_data, e0);
      fails++;
    end
    tests++;
    if (bus.o_req_ready !== 1'b0) begin
      $display("FAIL widen_b0_req_ready: got %b want 0", bus.o_req_ready);
      fails++;
    end
    step();
    tests++;
    if (ctl !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9}) begin
      $display("FAIL widen_b1_ctl: got %b want %b", ctl, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9});
      fails++;
    end
    tests++;
    if (bus.o_enc_data !== e1) begin
      $display("FAIL widen_b1_data: got %h want %h", bus.o_enc_data, e1);
      fails++;
    end
    step();
    tests++;
    if (bus.o_rsp_valid !== 1'b0) begin
      $display("FAIL widen_done: got valid %b want 0", bus.o_rsp_valid);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [4];
    d[0] = {4{64'h1000_0000_0000_0001}};
    d[1] = {4{64'h2000_0000_0000_0002}};
    d[2] = {4{64'h3000_0000_0000_0003}};
    d[3] = {4{64'h4000_0000_0000_0004}};
    drive_req(1'b1, d[0], 2'b10, 1'b0, 6'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      drive_req(1'b1, d[i+1], 2'b10, 1'b0, TW'(i + 2));
      tests++;
      if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, TW'(i + 1)} || bus.o_enc_data !== d[i]) begin
        $display("FAIL b2b_beat%0d: got ctl %b data %h want tag %0d data %h",
                 i, ctl, bus.o_enc_data, i + 1, d[i]);
        fails++;
      end
    end
    // Stall on request 3's beat with request 4 pending.
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3} || bus.o_enc_data !== d[2] ||
          bus.o_req_ready !== 1'b0) begin
        $display("FAIL stall_hold%0d: got ctl %b data %h req_ready %b want tag 3 held, ready 0",
                 i, ctl, bus.o_enc_data, bus.o_req_ready);
        fails++;
      end
      step();
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    tests++;
    if (bus.o_req_ready !== 1'b1) begin
      $display("FAIL stall_release_ready: got %b want 1", bus.o_req_ready);
      fails++;
    end
    step();
    drive_req(1'b0, '0, 2'b00, 1'b0, '0);
    tests++;
    if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4} || bus.o_enc_data !== d[3]) begin
      $display("FAIL b2b_after_stall: got ctl %b data %h want tag 4 data %h",
               ctl, bus.o_enc_data, d[3]);
      fails++;
    end
    step();
    tests++;
    if (bus.o_rsp_valid !== 1'b0) begin
      $display("FAIL b2b_done: got valid %b want 0", bus.o_rsp_valid);
      fails++;
    end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] d;
    d = {4{64'h400921FB_54442D18}};
    drive_req(1'b1, d, 2'b11, 1'b1, 6'd7);
    step();
    drive_req(1'b0, '0, 2'b00, 1'b0, '0);
    tests++;
    if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7} || bus.o_enc_data !== d) begin
      $display("FAIL illegal_beat: got ctl %b data %h want %b data %h",
               ctl, bus.o_enc_data, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7}, d);
      fails++;
    end
    step();
    tests++;
    if (bus.o_rsp_valid !== 1'b0) begin
      $display("FAIL illegal_done: got valid %b want 0", bus.o_rsp_valid);
      fails++;
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] dw;
    logic [DW-1:0] dn;
    dw = {4{64'hAAAA_BBBB_CCCC_DDDD}};
    dn = {4{64'h0BAD_F00D_1234_5678}};
    drive_req(1'b1, dw, 2'b10, 1'b1, 6'd12);
    step();
    drive_req(1'b1, dn, 2'b10, 1'b0, 6'd13);
    bus.i_flush = 1'b1;
    #1;
    tests++;
    if (bus.o_req_ready !== 1'b0) begin
      $display("FAIL flush_req_ready: got %b want 0", bus.o_req_ready);
      fails++;
    end
    step();
    bus.i_flush = 1'b0;
    tests++;
    if (bus.o_rsp_valid !== 1'b0) begin
      $display("FAIL flush_kill: got valid %b want 0", bus.o_rsp_valid);
      fails++;
    end
    #1;
    tests++;
    if (bus.o_req_ready !== 1'b1) begin
      $display("FAIL flush_after_ready: got %b want 1", bus.o_req_ready);
      fails++;
    end
    step();
    drive_req(1'b0, '0, 2'b00, 1'b0, '0);
    tests++;
    if (ctl !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd13} || bus.o_enc_data !== dn) begin
      $display("FAIL flush_pending_accept: got ctl %b data %h want tag 13 data %h",
               ctl, bus.o_enc_data, dn);
      fails++;
    end
    step();
    tests++;
    if (bus.o_rsp_valid !== 1'b0) begin
      $display("FAIL flush_done: got valid %b want 0", bus.o_rsp_valid);
      fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_nonwiden();
    test_widen();
    test_back_to_back();
    test_illegal();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tt_vfp_encoder_seq.md
# tt_vfp_encoder_seq

Sequencer that feeds vector source operands into an array of `NUM_LANES` FP encoder lanes. The lanes convert IEEE f16/f32/f64 into recoded format and optionally upscale one width step. A lane upscales only its low 32 bits, so a full 64-bit-per-lane widening operand takes two passes. This block accepts operand requests on a valid/ready handshake, registers them, and drives the lane `data_in`/`data_sel` pins for one beat (same width) or two beats (widen). It presents each beat to the downstream FP pipeline on a second valid/ready handshake.

## Interface
Parameters:
- `NUM_LANES`, 4: number of 64-bit encoder lanes driven.
- `TAG_W`, 6: width of the request tag carried to the response.

Ports:
- `i_clk`  in  1  clock. One clock domain; all logic is rising-edge.
- `i_reset`  in  1  reset, asynchronous and active-high.
- `i_req_valid`  in  1  operand request valid.
- `o_req_ready`  out  1  request accepted when `i_req_valid & o_req_ready` is high at a rising edge.
- `i_req_data`  in  64*NUM_LANES  source operand; lane k is bits [64k+63:64k].
- `i_req_sew`  in  2  source element width: 01 = e16, 10 = e32, 11 = e64, 00 = reserved.
- `i_req_widen`  in  1  request upscale, e16→e32 or e32→e64.
- `i_req_tag`  in  TAG_W  opaque tag.
- `i_flush`  in  1  synchronous kill of the in-flight request.
- `o_enc_data`  out  64*NUM_LANES  driven to each lane's `data_in`.
- `o_enc_sel`  out  1  driven to every lane's `data_sel` (1 = upscale).
- `o_rsp_valid`  out  1  lane outputs for the current beat are valid this cycle.
- `i_rsp_ready`  in  1  downstream accepts the current beat.
- `o_rsp_beat`  out  1  beat index: 0 = low halves, 1 = high halves.
- `o_rsp_last`  out  1  final beat of the request.
- `o_rsp_tag`  out  TAG_W  tag of the request being output.
- `o_rsp_illegal`  out  1  the request asked for widen with sew 11 or 00.

## Operation
- States: IDLE, BEAT0, BEAT1. All outputs except `o_req_ready` come from registers.
- On accept, latch `i_req_data`, tag and mode into the holding register.
  - Effective widen = `i_req_widen & (sew==01 | sew==10)`.
  - `o_rsp_illegal` = `i_req_widen & (sew==11 | sew==00)`.
- Non-widen request (including illegal):
  - Enter BEAT0 with `o_enc_data` = latched data and `o_enc_sel` = 0.
  - `o_rsp_beat` = 0, `o_rsp_last` = 1.
- Widen request:
  - BEAT0: each lane k outputs {32'b0, lane_k[31:0]}, `o_enc_sel` = 1, `o_rsp_last` = 0.
  - After BEAT0 handshakes, go to BEAT1: each lane k outputs {32'b0, lane_k[63:32]}, `o_enc_sel` = 1, `o_rsp_beat` = 1, `o_rsp_last` = 1.
- `o_rsp_valid` = 1 in BEAT0 and BEAT1, 0 in IDLE.
- Stall: while `o_rsp_valid & !i_rsp_ready`, every registered output holds stable.
- `o_req_ready` = (state==IDLE) | (`o_rsp_valid & i_rsp_ready & o_rsp_last`). This is a combinational path from `i_rsp_ready` and allows back-to-back requests.
- Handshake of the last beat:
  - With a new accept in the same cycle, go to BEAT0 of the new request.
  - Otherwise go to IDLE.
- `i_flush`:
  - Forces the next state to IDLE and clears `o_rsp_valid`.
  - Has priority over both accept and beat advance.
  - `o_req_ready` is forced to 0 while `i_flush` = 1, so no request is accepted in a flush cycle.
- In IDLE, `o_enc_data`, `o_enc_sel`, tag, beat, last and illegal all hold their last values. Consumers qualify them with `o_rsp_valid`.

## Timing
- Reset (async assert) forces:
  - state = IDLE; `o_rsp_valid` = 0.
  - `o_enc_data` = 0, `o_enc_sel` = 0, `o_rsp_beat` = 0, `o_rsp_last` = 0, `o_rsp_tag` = 0, `o_rsp_illegal` = 0.
  - `o_req_ready` = 1 once `i_reset` deasserts.
- Latency: a request accepted at edge N gives `o_rsp_valid` = 1 in cycle N+1. The encoder lanes are combinational, so lane outputs are valid in the same cycle.
- Throughput, no stalls: a non-widen request is 1 beat per cycle; a widen request is 2 cycles.
- Reset asserted mid-request drops the request; no beat is replayed.

## Test plan
- Reset then idle: after reset release, `o_rsp_valid` = 0, `o_req_ready` = 1, `o_enc_data` = 0.
- Non-widen e32, tag 5, lane0 = 0x40490FDB_3F800000, `i_rsp_ready` held 1:
  - One cycle later one beat: sel 0, beat 0, last 1, tag 5, `o_enc_data` = input.
- Widen e16, lane0 = 0x4400_4000_3C00_3800, `i_rsp_ready` = 1:
  - Beat0: lane0 = 0x00000000_3C003800, sel 1, last 0.
  - Beat1: lane0 = 0x00000000_44004000, sel 1, last 1.
- Back-to-back plus stall:
  - Three non-widen requests with `i_rsp_ready` = 1: three consecutive valid cycles.
  - Drop `i_rsp_ready` for 3 cycles mid-stream: outputs hold, `o_req_ready` = 0, no beat lost or duplicated.
- Illegal widen (sew 11, widen 1): one beat, sel 0, last 1, `o_rsp_illegal` = 1.
- Flush in BEAT0 of a widen request with `i_req_valid` = 1 in the same cycle:
  - Next cycle `o_rsp_valid` = 0, no BEAT1.
  - The pending request is accepted the cycle after the flush.
